// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator leaf-bank logic: default bank geometry,
// requester owner encoding and the read-return tag carried alongside each access.
package acc_pkg;

  localparam int unsigned LEAF_ADDR_W = 6;
  localparam int unsigned LEAF_DATA_W = 64;

  localparam logic OWN_ACC = 1'b0;
  localparam logic OWN_WBS = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Latency-matched {valid, owner} shift register: a tag pushed with an access
// appears at tag_out exactly RD_LAT cycles later, aligned with the SRAM read data.
module rd_tag_pipe
  import acc_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [RD_LAT-1:0] stage_r;

  // shift tags one stage per clock; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= '0;
    end else begin
      stage_r[0] <= tag_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tag_out = stage_r[RD_LAT-1];

endmodule

// File: rtl/leaf_mem_arbiter.sv
// Single-port leaf SRAM arbiter: accelerator has fixed priority, a starvation
// counter force-grants the debug port, and read data is routed back by tag.
module leaf_mem_arbiter
  import acc_pkg::*;
#(
  parameter int unsigned ADDR_W       = LEAF_ADDR_W,
  parameter int unsigned DATA_W       = LEAF_DATA_W,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              debug_en,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] acc_rdata,
  input  logic              wbs_req,
  input  logic              wbs_we,
  input  logic [ADDR_W-1:0] wbs_addr,
  input  logic [DATA_W-1:0] wbs_wdata,
  output logic              wbs_gnt,
  output logic              wbs_rvalid,
  output logic [DATA_W-1:0] wbs_rdata,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starve_force
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt_r;
  logic [3:0]        starve_cnt_nxt_s;
  logic              wreq_s;
  logic              force_s;
  logic              wbs_gnt_s;
  logic              acc_gnt_s;
  rd_tag_t           push_tag_s;
  rd_tag_t           pop_tag_s;
  logic [DATA_W-1:0] acc_rdata_r;
  logic [DATA_W-1:0] wbs_rdata_r;

  // grant decision and SRAM drive; rst_n gating keeps the bank idle during reset
  always_comb begin
    wreq_s     = wbs_req & debug_en & rst_n;
    force_s    = wreq_s & (starve_cnt_r == LIMIT);
    wbs_gnt_s  = wreq_s & (~acc_req | force_s);
    acc_gnt_s  = acc_req & rst_n & ~wbs_gnt_s;
    mem_csb    = 1'b1;
    mem_web    = 1'b1;
    mem_addr   = '0;
    mem_wdata  = '0;
    push_tag_s = '0;
    if (wbs_gnt_s) begin
      mem_csb          = 1'b0;
      mem_web          = ~wbs_we;
      mem_addr         = wbs_addr;
      mem_wdata        = wbs_wdata;
      push_tag_s.valid = ~wbs_we;
      push_tag_s.owner = OWN_WBS;
    end else if (acc_gnt_s) begin
      mem_csb          = 1'b0;
      mem_web          = ~acc_we;
      mem_addr         = acc_addr;
      mem_wdata        = acc_wdata;
      push_tag_s.valid = ~acc_we;
      push_tag_s.owner = OWN_ACC;
    end else begin
      push_tag_s.owner = OWN_ACC;
    end
  end

  assign acc_gnt      = acc_gnt_s;
  assign wbs_gnt      = wbs_gnt_s;
  assign starve_force = force_s & wbs_gnt_s;

  // count consecutive denied debug cycles, saturating at the force threshold
  always_comb begin
    if (wbs_gnt_s || !wreq_s) begin
      starve_cnt_nxt_s = 4'd0;
    end else if (starve_cnt_r != LIMIT) begin
      starve_cnt_nxt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (push_tag_s),
    .tag_out (pop_tag_s)
  );

  // return routing: the owner sees live SRAM data, the other side keeps its last word
  always_comb begin
    acc_rvalid = pop_tag_s.valid & (pop_tag_s.owner == OWN_ACC);
    wbs_rvalid = pop_tag_s.valid & (pop_tag_s.owner == OWN_WBS);
    if (acc_rvalid) begin
      acc_rdata = mem_rdata;
    end else begin
      acc_rdata = acc_rdata_r;
    end
    if (wbs_rvalid) begin
      wbs_rdata = mem_rdata;
    end else begin
      wbs_rdata = wbs_rdata_r;
    end
  end

  // hold the most recent read word per requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_rdata_r <= '0;
      wbs_rdata_r <= '0;
    end else begin
      if (acc_rvalid) begin
        acc_rdata_r <= mem_rdata;
      end
      if (wbs_rvalid) begin
        wbs_rdata_r <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_leaf_mem_arbiter.sv
// Self-checking bench: two arbiters (RD_LAT=1 and RD_LAT=2) share stimulus; a
// behavioural model predicts grants and a return scoreboard checks read data.
module tb_leaf_mem_arbiter;

  localparam int AW  = 6;
  localparam int DW  = 64;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic debug_en, acc_req, acc_we, wbs_req, wbs_we;
  logic [AW-1:0] acc_addr, wbs_addr;
  logic [DW-1:0] acc_wdata, wbs_wdata;

  logic          acc_gnt [2], acc_rvalid [2], wbs_gnt [2], wbs_rvalid [2];
  logic          mem_csb [2], mem_web [2], starve_force [2];
  logic [DW-1:0] acc_rdata [2], wbs_rdata [2], mem_wdata [2];
  logic [AW-1:0] mem_addr [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int            due;
    logic          owner;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          rq [2][$];
  logic [DW-1:0] shadow [64];
  logic [DW-1:0] last_acc [2];
  logic [DW-1:0] last_wbs [2];
  int            denied = 0;
  logic          m_acc_gnt, m_wbs_gnt, m_force, m_csb, m_web;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 5) return 64'h0000_0000_0000_00A5;
    return 64'hC0DE_0000_0000_0000 + 64'(i * 3 + 1);
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] sram [64];
    logic [DW-1:0] r1, r2, rdata;

    initial for (int i = 0; i < 64; i++) sram[i] = init_val(i);

    always @(posedge clk) begin
      if (!mem_csb[g] && !mem_web[g]) sram[mem_addr[g]] <= mem_wdata[g];
      if (!mem_csb[g] && mem_web[g]) r1 <= sram[mem_addr[g]];
      r2 <= r1;
    end
    assign rdata = (g == 0) ? r1 : r2;

    leaf_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LAT(g + 1), .STARVE_LIMIT(LIM)
    ) dut (
      .clk(clk), .rst_n(rst_n), .debug_en(debug_en),
      .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
      .acc_gnt(acc_gnt[g]), .acc_rvalid(acc_rvalid[g]), .acc_rdata(acc_rdata[g]),
      .wbs_req(wbs_req), .wbs_we(wbs_we), .wbs_addr(wbs_addr), .wbs_wdata(wbs_wdata),
      .wbs_gnt(wbs_gnt[g]), .wbs_rvalid(wbs_rvalid[g]), .wbs_rdata(wbs_rdata[g]),
      .mem_csb(mem_csb[g]), .mem_web(mem_web[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(rdata), .starve_force(starve_force[g])
    );
  end

  // Behavioural model of one arbitration cycle, evaluated on the current inputs.
  task automatic model_step();
    bit wreq, own, we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    wreq      = wbs_req && debug_en;
    m_wbs_gnt = wreq && (!acc_req || denied == LIM);
    m_force   = m_wbs_gnt && (denied == LIM);
    m_acc_gnt = acc_req && !m_wbs_gnt;
    own = m_wbs_gnt;
    we  = own ? wbs_we : acc_we;
    a   = own ? wbs_addr : acc_addr;
    wd  = own ? wbs_wdata : acc_wdata;
    m_csb = 1'b1; m_web = 1'b1; m_addr = '0; m_wdata = '0;
    if (m_acc_gnt || m_wbs_gnt) begin
      m_csb = 1'b0; m_web = !we; m_addr = a; m_wdata = wd;
      if (we) shadow[a] = wd;
      else for (int d = 0; d < 2; d++) rq[d].push_back('{due: cyc + d + 1, owner: own, data: shadow[a]});
    end
    if (wreq && acc_req && !m_wbs_gnt) denied = (denied < LIM) ? denied + 1 : LIM;
    else denied = 0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      rq[d].delete();
      last_acc[d] = '0;
      last_wbs[d] = '0;
    end
    denied = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Return scoreboard: every cycle out of reset, rvalid/rdata must match the queued reads.
  bit   mon_ea, mon_ew;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        mon_ea = 1'b0; mon_ew = 1'b0;
        if (rq[d].size() > 0 && rq[d][0].due == cyc) begin
          mon_e = rq[d].pop_front();
          if (mon_e.owner) begin mon_ew = 1'b1; last_wbs[d] = mon_e.data; end
          else begin mon_ea = 1'b1; last_acc[d] = mon_e.data; end
        end
        checks++;
        if (acc_rvalid[d] !== mon_ea) begin errors++; $display("FAIL ret_acc_rvalid dut%0d cyc %0d got %0b exp %0b", d, cyc, acc_rvalid[d], mon_ea); end
        checks++;
        if (wbs_rvalid[d] !== mon_ew) begin errors++; $display("FAIL ret_wbs_rvalid dut%0d cyc %0d got %0b exp %0b", d, cyc, wbs_rvalid[d], mon_ew); end
        checks++;
        if (acc_rdata[d] !== last_acc[d]) begin errors++; $display("FAIL ret_acc_rdata dut%0d cyc %0d got %0h exp %0h", d, cyc, acc_rdata[d], last_acc[d]); end
        checks++;
        if (wbs_rdata[d] !== last_wbs[d]) begin errors++; $display("FAIL ret_wbs_rdata dut%0d cyc %0d got %0h exp %0h", d, cyc, wbs_rdata[d], last_wbs[d]); end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; acc_req = 1'b1; wbs_req = 1'b1; acc_we = 1'b1; debug_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++; if (acc_gnt[d] !== 1'b0) begin errors++; $display("FAIL rst_acc_gnt dut%0d got %0b exp 0", d, acc_gnt[d]); end
        checks++; if (wbs_gnt[d] !== 1'b0) begin errors++; $display("FAIL rst_wbs_gnt dut%0d got %0b exp 0", d, wbs_gnt[d]); end
        checks++; if (mem_csb[d] !== 1'b1) begin errors++; $display("FAIL rst_csb dut%0d got %0b exp 1", d, mem_csb[d]); end
        checks++; if (mem_web[d] !== 1'b1) begin errors++; $display("FAIL rst_web dut%0d got %0b exp 1", d, mem_web[d]); end
        checks++; if (starve_force[d] !== 1'b0) begin errors++; $display("FAIL rst_force dut%0d got %0b exp 0", d, starve_force[d]); end
        checks++; if (acc_rvalid[d] !== 1'b0 || wbs_rvalid[d] !== 1'b0) begin errors++; $display("FAIL rst_rvalid dut%0d got %0b%0b exp 00", d, acc_rvalid[d], wbs_rvalid[d]); end
      end
    end
    next_cycle();
    acc_req = 1'b0; wbs_req = 1'b0; acc_we = 1'b0; rst_n = 1'b1;
    @(negedge clk); model_step();
    checks++; if (mem_csb[0] !== 1'b1) begin errors++; $display("FAIL idle_csb got %0b exp 1", mem_csb[0]); end
    checks++; if (mem_addr[0] !== 6'd0 || mem_wdata[0] !== 64'd0) begin errors++; $display("FAIL idle_fields got %0h/%0h exp 0/0", mem_addr[0], mem_wdata[0]); end
    next_cycle();
  endtask

  task automatic test_acc_read();
    acc_req = 1'b1; acc_we = 1'b0; acc_addr = 6'd5;
    @(negedge clk); model_step();
    checks++; if (acc_gnt[0] !== 1'b1) begin errors++; $display("FAIL rd_acc_gnt got %0b exp 1", acc_gnt[0]); end
    checks++; if (mem_csb[0] !== 1'b0 || mem_web[0] !== 1'b1) begin errors++; $display("FAIL rd_csb_web got %0b%0b exp 01", mem_csb[0], mem_web[0]); end
    checks++; if (mem_addr[0] !== 6'd5) begin errors++; $display("FAIL rd_addr got %0d exp 5", mem_addr[0]); end
    next_cycle();
    acc_req = 1'b0;
    @(negedge clk); model_step();
    checks++; if (acc_rvalid[0] !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %0b exp 1", acc_rvalid[0]); end
    checks++; if (acc_rdata[0] !== 64'hA5) begin errors++; $display("FAIL rd_rdata got %0h exp a5", acc_rdata[0]); end
    checks++; if (wbs_rvalid[0] !== 1'b0) begin errors++; $display("FAIL rd_wbs_rvalid got %0b exp 0", wbs_rvalid[0]); end
    next_cycle();
    @(negedge clk); model_step();
    next_cycle();
  endtask

  task automatic test_starvation();
    acc_req = 1'b1; wbs_req = 1'b1; acc_we = 1'b0; wbs_we = 1'b0;
    acc_addr = 6'd10; wbs_addr = 6'd11; debug_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); model_step();
      checks++; if (wbs_gnt[0] !== (i % 5 == 4)) begin errors++; $display("FAIL starve_wbs_gnt i=%0d got %0b exp %0b", i, wbs_gnt[0], (i % 5 == 4)); end
      checks++; if (acc_gnt[0] !== (i % 5 != 4)) begin errors++; $display("FAIL starve_acc_gnt i=%0d got %0b exp %0b", i, acc_gnt[0], (i % 5 != 4)); end
      checks++; if (starve_force[0] !== (i % 5 == 4)) begin errors++; $display("FAIL starve_force i=%0d got %0b exp %0b", i, starve_force[0], (i % 5 == 4)); end
      next_cycle();
    end
    acc_req = 1'b0; wbs_req = 1'b0;
  endtask

  task automatic test_debug_en();
    logic exp_w, exp_a;
    wbs_req = 1'b1; wbs_we = 1'b0; wbs_addr = 6'd7; acc_we = 1'b0; acc_addr = 6'd12;
    for (int i = 0; i < 10; i++) begin
      debug_en = !(i == 0 || i == 4);
      acc_req  = (i >= 2);
      exp_w = (i == 1 || i == 9);
      exp_a = acc_req && !exp_w;
      @(negedge clk); model_step();
      checks++; if (wbs_gnt[0] !== exp_w) begin errors++; $display("FAIL dbg_wbs_gnt i=%0d got %0b exp %0b", i, wbs_gnt[0], exp_w); end
      checks++; if (acc_gnt[0] !== exp_a) begin errors++; $display("FAIL dbg_acc_gnt i=%0d got %0b exp %0b", i, acc_gnt[0], exp_a); end
      checks++; if (mem_csb[0] !== !(exp_a || exp_w)) begin errors++; $display("FAIL dbg_csb i=%0d got %0b exp %0b", i, mem_csb[0], !(exp_a || exp_w)); end
      next_cycle();
    end
    acc_req = 1'b0; wbs_req = 1'b0; debug_en = 1'b1;
  endtask

  task automatic test_write_read();
    wbs_req = 1'b1; wbs_we = 1'b1; wbs_addr = 6'd3; wbs_wdata = 64'h1234;
    @(negedge clk); model_step();
    checks++; if (wbs_gnt[0] !== 1'b1 || mem_web[0] !== 1'b0) begin errors++; $display("FAIL wr_gnt_web got %0b%0b exp 10", wbs_gnt[0], mem_web[0]); end
    checks++; if (mem_addr[0] !== 6'd3 || mem_wdata[0] !== 64'h1234) begin errors++; $display("FAIL wr_fields got %0h/%0h exp 3/1234", mem_addr[0], mem_wdata[0]); end
    next_cycle();
    wbs_req = 1'b0; acc_req = 1'b1; acc_we = 1'b0; acc_addr = 6'd3;
    @(negedge clk); model_step();
    checks++; if (acc_gnt[0] !== 1'b1) begin errors++; $display("FAIL wr_rd_gnt got %0b exp 1", acc_gnt[0]); end
    next_cycle();
    acc_req = 1'b0;
    @(negedge clk); model_step();
    checks++; if (acc_rvalid[0] !== 1'b1 || acc_rdata[0] !== 64'h1234) begin errors++; $display("FAIL wr_rd_lat1 got %0b/%0h exp 1/1234", acc_rvalid[0], acc_rdata[0]); end
    checks++; if (acc_rvalid[1] !== 1'b0) begin errors++; $display("FAIL wr_rd_lat2_early got %0b exp 0", acc_rvalid[1]); end
    next_cycle();
    @(negedge clk); model_step();
    checks++; if (acc_rvalid[1] !== 1'b1 || acc_rdata[1] !== 64'h1234) begin errors++; $display("FAIL wr_rd_lat2 got %0b/%0h exp 1/1234", acc_rvalid[1], acc_rdata[1]); end
    checks++; if (acc_rvalid[0] !== 1'b0 || acc_rdata[0] !== 64'h1234) begin errors++; $display("FAIL wr_rd_hold got %0b/%0h exp 0/1234", acc_rvalid[0], acc_rdata[0]); end
    next_cycle();
  endtask

  task automatic test_alternate();
    int prev;
    logic [DW-1:0] pdata;
    prev = -1; pdata = '0;
    acc_we = 1'b0; wbs_we = 1'b0; debug_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      acc_req  = (i < 8) && (i % 2 == 0);
      wbs_req  = (i < 8) && (i % 2 == 1);
      acc_addr = AW'(i + 8);
      wbs_addr = AW'(i + 24);
      @(negedge clk); model_step();
      if (prev >= 0) begin
        checks++; if (acc_rvalid[0] !== (prev == 0)) begin errors++; $display("FAIL alt_acc_rvalid i=%0d got %0b exp %0b", i, acc_rvalid[0], (prev == 0)); end
        checks++; if (wbs_rvalid[0] !== (prev == 1)) begin errors++; $display("FAIL alt_wbs_rvalid i=%0d got %0b exp %0b", i, wbs_rvalid[0], (prev == 1)); end
        checks++; if ((prev == 0 ? acc_rdata[0] : wbs_rdata[0]) !== pdata) begin errors++; $display("FAIL alt_rdata i=%0d got %0h exp %0h", i, (prev == 0 ? acc_rdata[0] : wbs_rdata[0]), pdata); end
      end
      checks++; if (acc_gnt[0] !== acc_req || wbs_gnt[0] !== wbs_req) begin errors++; $display("FAIL alt_gnt i=%0d got %0b%0b exp %0b%0b", i, acc_gnt[0], wbs_gnt[0], acc_req, wbs_req); end
      prev  = acc_req ? 0 : (wbs_req ? 1 : -1);
      pdata = acc_req ? init_val(i + 8) : init_val(i + 24);
      next_cycle();
    end
  endtask

  task automatic test_random();
    bit acc_pend, wbs_pend;
    acc_pend = 1'b0; wbs_pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!acc_pend && $urandom_range(0, 1) == 1) begin
        acc_pend = 1'b1; acc_we = 1'($urandom); acc_addr = AW'($urandom_range(0, 15));
        acc_wdata = {$urandom, $urandom};
      end
      if (!wbs_pend && $urandom_range(0, 2) != 0) begin
        wbs_pend = 1'b1; wbs_we = 1'($urandom); wbs_addr = AW'($urandom_range(0, 15));
        wbs_wdata = {$urandom, $urandom};
      end
      acc_req = acc_pend; wbs_req = wbs_pend;
      debug_en = ($urandom_range(0, 9) != 0);
      @(negedge clk); model_step();
      checks++; if (acc_gnt[0] !== m_acc_gnt) begin errors++; $display("FAIL rnd_acc_gnt cyc %0d got %0b exp %0b", cyc, acc_gnt[0], m_acc_gnt); end
      checks++; if (wbs_gnt[0] !== m_wbs_gnt) begin errors++; $display("FAIL rnd_wbs_gnt cyc %0d got %0b exp %0b", cyc, wbs_gnt[0], m_wbs_gnt); end
      checks++; if (starve_force[0] !== m_force) begin errors++; $display("FAIL rnd_force cyc %0d got %0b exp %0b", cyc, starve_force[0], m_force); end
      checks++; if (mem_csb[0] !== m_csb || mem_web[0] !== m_web) begin errors++; $display("FAIL rnd_csb_web cyc %0d got %0b%0b exp %0b%0b", cyc, mem_csb[0], mem_web[0], m_csb, m_web); end
      checks++; if (mem_addr[0] !== m_addr || mem_wdata[0] !== m_wdata) begin errors++; $display("FAIL rnd_fields cyc %0d got %0h/%0h exp %0h/%0h", cyc, mem_addr[0], mem_wdata[0], m_addr, m_wdata); end
      if (m_acc_gnt) acc_pend = 1'b0;
      if (m_wbs_gnt) wbs_pend = 1'b0;
      next_cycle();
    end
    acc_req = 1'b0; wbs_req = 1'b0; debug_en = 1'b1;
  endtask

  task automatic test_reset_inflight();
    acc_req = 1'b1; wbs_req = 1'b1; acc_we = 1'b0; wbs_we = 1'b0;
    acc_addr = 6'd5; wbs_addr = 6'd6; debug_en = 1'b1;
    repeat (3) begin
      @(negedge clk); model_step();
      next_cycle();
    end
    // a read was granted at the last edge and is still in flight
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (acc_gnt[d] !== 1'b0 || wbs_gnt[d] !== 1'b0) begin errors++; $display("FAIL inflt_gnt dut%0d got %0b%0b exp 00", d, acc_gnt[d], wbs_gnt[d]); end
      checks++; if (mem_csb[d] !== 1'b1) begin errors++; $display("FAIL inflt_csb dut%0d got %0b exp 1", d, mem_csb[d]); end
      checks++; if (acc_rvalid[d] !== 1'b0 || wbs_rvalid[d] !== 1'b0) begin errors++; $display("FAIL inflt_rvalid dut%0d got %0b%0b exp 00", d, acc_rvalid[d], wbs_rvalid[d]); end
    end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      else #1;
      model_step();
      checks++; if (wbs_gnt[0] !== (i % 5 == 4)) begin errors++; $display("FAIL inflt_wbs_gnt i=%0d got %0b exp %0b", i, wbs_gnt[0], (i % 5 == 4)); end
      checks++; if (acc_gnt[0] !== (i % 5 != 4)) begin errors++; $display("FAIL inflt_acc_gnt i=%0d got %0b exp %0b", i, acc_gnt[0], (i % 5 != 4)); end
      if (i == 1) begin
        checks++; if (acc_rvalid[1] !== 1'b0) begin errors++; $display("FAIL inflt_lat2_ghost got %0b exp 0", acc_rvalid[1]); end
      end
      next_cycle();
    end
    acc_req = 1'b0; wbs_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; debug_en = 1'b1;
    acc_req = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0;
    wbs_req = 1'b0; wbs_we = 1'b0; wbs_addr = '0; wbs_wdata = '0;
    for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
    model_reset();
    #2;
    test_reset();
    test_acc_read();
    test_starvation();
    test_debug_en();
    test_write_read();
    test_alternate();
    test_random();
    test_reset_inflight();
    repeat (3) begin
      @(negedge clk); model_step();
      next_cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
